// File: rtl/pipe_control_unit.sv
// rtl/pipe_control_unit.sv - pipelined MIPS control unit: ID decode, ID/EX, EX/MEM and MEM/WB control registers, multi-cycle mul hold.
// Optional extended opcodes (bne, andi, ori, slti, jal and the link_e port) are enabled by defining CTRL_EXT_ISA_EN.
module pipe_control_unit #(
  parameter int ALUC_W  = 3,
  parameter int MUL_LAT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [5:0]        op_d,
  input  logic [5:0]        funct_d,
  input  logic              stall_d,
  input  logic              flush_e,
  output logic              branch_d,
  output logic              jump_d,
  output logic [ALUC_W-1:0] alu_control_e,
  output logic              alusrc_e,
  output logic              regdst_e,
  output logic              regwrite_e,
  output logic              regwrite_m,
  output logic              regwrite_w,
  output logic              memtoreg_e,
  output logic              memtoreg_m,
  output logic              memtoreg_w,
  output logic              memwrite_e,
  output logic              memwrite_m,
  output logic              mul_busy
`ifdef CTRL_EXT_ISA_EN
  ,
  output logic              link_e
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
`ifdef CTRL_EXT_ISA_EN
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
`endif

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b011000;

  localparam logic [ALUC_W-1:0] ALU_ADD = ALUC_W'(3'b010);
  localparam logic [ALUC_W-1:0] ALU_SUB = ALUC_W'(3'b110);
  localparam logic [ALUC_W-1:0] ALU_AND = ALUC_W'(3'b000);
  localparam logic [ALUC_W-1:0] ALU_OR  = ALUC_W'(3'b001);
  localparam logic [ALUC_W-1:0] ALU_SLT = ALUC_W'(3'b111);
  localparam logic [ALUC_W-1:0] ALU_MUL = ALUC_W'(3'b011);

  localparam int               CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LAT - 1);

  logic [ALUC_W-1:0] dec_alu;
  logic              dec_alusrc;
  logic              dec_regdst;
  logic              dec_regwrite;
  logic              dec_memtoreg;
  logic              dec_memwrite;
  logic              dec_mul;
  logic              dec_link;
  logic [CNT_W-1:0]  mul_cnt;

  always_comb begin
    dec_alu      = ALU_ADD;
    dec_alusrc   = 1'b0;
    dec_regdst   = 1'b0;
    dec_regwrite = 1'b0;
    dec_memtoreg = 1'b0;
    dec_memwrite = 1'b0;
    dec_mul      = 1'b0;
    dec_link     = 1'b0;
    branch_d     = 1'b0;
    jump_d       = 1'b0;
    case (op_d)
      OP_RTYPE: begin
        dec_regwrite = 1'b1;
        dec_regdst   = 1'b1;
        case (funct_d)
          FN_ADD:  dec_alu = ALU_ADD;
          FN_SUB:  dec_alu = ALU_SUB;
          FN_AND:  dec_alu = ALU_AND;
          FN_OR:   dec_alu = ALU_OR;
          FN_SLT:  dec_alu = ALU_SLT;
          FN_MUL: begin
            dec_alu = ALU_MUL;
            dec_mul = 1'b1;
          end
          default: dec_alu = ALU_ADD;
        endcase
      end
      OP_LW: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_memtoreg = 1'b1;
      end
      OP_SW: begin
        dec_alusrc   = 1'b1;
        dec_memwrite = 1'b1;
      end
      OP_BEQ: begin
        branch_d = 1'b1;
        dec_alu  = ALU_SUB;
      end
      OP_ADDI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
      end
      OP_J: jump_d = 1'b1;
`ifdef CTRL_EXT_ISA_EN
      OP_BNE: begin
        branch_d = 1'b1;
        dec_alu  = ALU_SUB;
      end
      OP_ANDI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_alu      = ALU_AND;
      end
      OP_ORI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_alu      = ALU_OR;
      end
      OP_SLTI: begin
        dec_regwrite = 1'b1;
        dec_alusrc   = 1'b1;
        dec_alu      = ALU_SLT;
      end
      OP_JAL: begin
        jump_d       = 1'b1;
        dec_regwrite = 1'b1;
        dec_link     = 1'b1;
      end
`endif
      default: dec_alu = '0;
    endcase
    // A non-decoding opcode is a full bubble, including the ALU code.
    if (!(dec_regwrite || dec_memwrite || branch_d || dec_alusrc)) dec_alu = '0;
  end

  assign mul_busy = (mul_cnt != '0);

  // ID/EX: a busy mul freezes EX and wins over flush/stall.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_control_e <= '0;
      alusrc_e      <= 1'b0;
      regdst_e      <= 1'b0;
      regwrite_e    <= 1'b0;
      memtoreg_e    <= 1'b0;
      memwrite_e    <= 1'b0;
`ifdef CTRL_EXT_ISA_EN
      link_e        <= 1'b0;
`endif
      mul_cnt       <= '0;
    end else if (mul_busy) begin
      mul_cnt <= mul_cnt - 1'b1;
    end else if (flush_e || stall_d) begin
      alu_control_e <= '0;
      alusrc_e      <= 1'b0;
      regdst_e      <= 1'b0;
      regwrite_e    <= 1'b0;
      memtoreg_e    <= 1'b0;
      memwrite_e    <= 1'b0;
`ifdef CTRL_EXT_ISA_EN
      link_e        <= 1'b0;
`endif
      mul_cnt       <= '0;
    end else begin
      alu_control_e <= dec_alu;
      alusrc_e      <= dec_alusrc;
      regdst_e      <= dec_regdst;
      regwrite_e    <= dec_regwrite;
      memtoreg_e    <= dec_memtoreg;
      memwrite_e    <= dec_memwrite;
`ifdef CTRL_EXT_ISA_EN
      link_e        <= dec_link;
`endif
      mul_cnt       <= dec_mul ? MUL_LOAD : '0;
    end
  end

`ifndef CTRL_EXT_ISA_EN
  logic unused_link;
  assign unused_link = dec_link;
`endif

  // EX/MEM takes bubbles while the mul is still occupying EX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_m <= 1'b0;
      memtoreg_m <= 1'b0;
      memwrite_m <= 1'b0;
    end else if (mul_busy) begin
      regwrite_m <= 1'b0;
      memtoreg_m <= 1'b0;
      memwrite_m <= 1'b0;
    end else begin
      regwrite_m <= regwrite_e;
      memtoreg_m <= memtoreg_e;
      memwrite_m <= memwrite_e;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regwrite_w <= 1'b0;
      memtoreg_w <= 1'b0;
    end else begin
      regwrite_w <= regwrite_m;
      memtoreg_w <= memtoreg_m;
    end
  end

endmodule

// File: tb/tb_pipe_control_unit.sv
// tb/tb_pipe_control_unit.sv - directed self-checking bench for pipe_control_unit (MUL_LAT=4, ALUC_W=3).
module tb_pipe_control_unit;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_BNE  = 6'b000101;
  localparam logic [5:0] OP_ORI  = 6'b001101;
  localparam logic [5:0] OP_NOP  = 6'b111111;

  logic       clk;
  logic       rst;
  logic [5:0] op_d;
  logic [5:0] funct_d;
  logic       stall_d;
  logic       flush_e;
  logic       branch_d;
  logic       jump_d;
  logic [2:0] alu_control_e;
  logic       alusrc_e;
  logic       regdst_e;
  logic       regwrite_e;
  logic       regwrite_m;
  logic       regwrite_w;
  logic       memtoreg_e;
  logic       memtoreg_m;
  logic       memtoreg_w;
  logic       memwrite_e;
  logic       memwrite_m;
  logic       mul_busy;
`ifdef CTRL_EXT_ISA_EN
  logic       link_e;
`endif

  int vectors;
  int miscompares;

  pipe_control_unit #(.ALUC_W(3), .MUL_LAT(4)) dut (
    .clk(clk),
    .rst(rst),
    .op_d(op_d),
    .funct_d(funct_d),
    .stall_d(stall_d),
    .flush_e(flush_e),
    .branch_d(branch_d),
    .jump_d(jump_d),
    .alu_control_e(alu_control_e),
    .alusrc_e(alusrc_e),
    .regdst_e(regdst_e),
    .regwrite_e(regwrite_e),
    .regwrite_m(regwrite_m),
    .regwrite_w(regwrite_w),
    .memtoreg_e(memtoreg_e),
    .memtoreg_m(memtoreg_m),
    .memtoreg_w(memtoreg_w),
    .memwrite_e(memwrite_e),
    .memwrite_m(memwrite_m),
    .mul_busy(mul_busy)
`ifdef CTRL_EXT_ISA_EN
    ,
    .link_e(link_e)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // EX bus layout: alu[2:0] alusrc regdst regwrite memtoreg memwrite
  function automatic logic [7:0] ex_bus();
    return {alu_control_e, alusrc_e, regdst_e, regwrite_e, memtoreg_e, memwrite_e};
  endfunction

  function automatic logic [2:0] mem_bus();
    return {regwrite_m, memtoreg_m, memwrite_m};
  endfunction

  function automatic logic [1:0] wb_bus();
    return {regwrite_w, memtoreg_w};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b0; op_d = OP_NOP; funct_d = 6'b0; stall_d = 1'b0; flush_e = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("rst_ex", 32'(ex_bus()), 32'h0);
    chk("rst_m", 32'(mem_bus()), 32'h0);
    chk("rst_w", 32'(wb_bus()), 32'h0);
    chk("rst_busy", 32'(mul_busy), 32'h0);
    op_d = OP_BEQ; #1;
    chk("rst_branch_d", 32'(branch_d), 32'h1);
    tick();
    rst = 1'b0;

    // lw flows E@1, M@2, W@3
    op_d = OP_LW;
    tick(); chk("lw_ex", 32'(ex_bus()), 32'(8'b010_1_0_1_1_0));
    op_d = OP_NOP;
    tick(); chk("lw_m", 32'(mem_bus()), 32'(3'b110)); chk("nop_ex", 32'(ex_bus()), 32'h0);
    tick(); chk("lw_w", 32'(wb_bus()), 32'(2'b11)); chk("nop_m", 32'(mem_bus()), 32'h0);

    // slt, then sw flushed, then sw
    op_d = OP_R; funct_d = 6'b101010;
    tick(); chk("slt_ex", 32'(ex_bus()), 32'(8'b111_0_1_1_0_0));
    op_d = OP_SW; flush_e = 1'b1;
    tick(); chk("flush_ex", 32'(ex_bus()), 32'h0);
    flush_e = 1'b0;
    tick(); chk("sw_ex", 32'(ex_bus()), 32'(8'b010_1_0_0_0_1));
    op_d = OP_ADDI; stall_d = 1'b1;
    tick(); chk("sw_m", 32'(mem_bus()), 32'(3'b001)); chk("stall_ex", 32'(ex_bus()), 32'h0);
    stall_d = 1'b0;
    tick(); chk("addi_ex", 32'(ex_bus()), 32'(8'b010_1_0_1_0_0));

    // beq and j
    op_d = OP_BEQ; #1;
    chk("beq_branch_d", 32'(branch_d), 32'h1);
    tick(); chk("beq_ex", 32'(ex_bus()), 32'(8'b110_0_0_0_0_0));
    op_d = OP_J; #1;
    chk("j_jump_d", 32'(jump_d), 32'h1);
    chk("j_branch_d", 32'(branch_d), 32'h0);
    tick(); chk("j_ex", 32'(ex_bus()), 32'h0);

    // R-type funct table
    op_d = OP_R; funct_d = 6'b100100;
    tick(); chk("and_ex", 32'(ex_bus()), 32'(8'b000_0_1_1_0_0));
    funct_d = 6'b100101;
    tick(); chk("or_ex", 32'(ex_bus()), 32'(8'b001_0_1_1_0_0));
    funct_d = 6'b100010;
    tick(); chk("sub_ex", 32'(ex_bus()), 32'(8'b110_0_1_1_0_0));
    funct_d = 6'b000111;
    tick(); chk("dflt_ex", 32'(ex_bus()), 32'(8'b010_0_1_1_0_0));
    op_d = OP_NOP;
    tick(); tick(); tick();

    // mul, MUL_LAT=4: busy after edges 1..3, flush during hold ignored
    op_d = OP_R; funct_d = 6'b011000;
    tick(); chk("mul_busy1", 32'(mul_busy), 32'h1); chk("mul_ex1", 32'(ex_bus()), 32'(8'b011_0_1_1_0_0));
    op_d = OP_LW;
    tick(); chk("mul_busy2", 32'(mul_busy), 32'h1); chk("mul_m2", 32'(mem_bus()), 32'h0);
    flush_e = 1'b1;
    tick(); chk("mul_busy3", 32'(mul_busy), 32'h1); chk("mul_ex3", 32'(ex_bus()), 32'(8'b011_0_1_1_0_0));
    chk("mul_m3", 32'(mem_bus()), 32'h0);
    flush_e = 1'b0;
    tick(); chk("mul_busy4", 32'(mul_busy), 32'h0); chk("mul_ex4", 32'(ex_bus()), 32'(8'b011_0_1_1_0_0));
    chk("mul_m4", 32'(mem_bus()), 32'h0);
    op_d = OP_NOP;
    op_d = OP_LW;
    tick(); chk("mul_m5", 32'(mem_bus()), 32'(3'b100)); chk("after_mul_ex", 32'(ex_bus()), 32'(8'b010_1_0_1_1_0));
    op_d = OP_NOP;
    tick(); chk("mul_w6", 32'(wb_bus()), 32'(2'b10));
    tick(); tick();

    // back-to-back mul: second one loads after first leaves, counter restarts
    op_d = OP_R; funct_d = 6'b011000;
    tick(); tick(); tick();
    tick(); chk("b2b_gap", 32'(mul_busy), 32'h0);
    tick(); chk("b2b_busy", 32'(mul_busy), 32'h1); chk("b2b_m", 32'(mem_bus()), 32'(3'b100));
    op_d = OP_NOP;
    tick(); tick(); chk("b2b_busy3", 32'(mul_busy), 32'h1);
    tick(); chk("b2b_done", 32'(mul_busy), 32'h0);
    tick(); chk("b2b_m2", 32'(mem_bus()), 32'(3'b100));
    tick(); tick();

    // reset during mul busy cycle 2
    op_d = OP_R; funct_d = 6'b011000;
    tick();
    op_d = OP_NOP;
    tick(); chk("pre_rst_busy", 32'(mul_busy), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 32'(mul_busy), 32'h0);
    chk("arst_ex", 32'(ex_bus()), 32'h0);
    chk("arst_m", 32'(mem_bus()), 32'h0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick(); chk($sformatf("no_mul_w%0d", i), 32'(regwrite_w), 32'h0);
    end

    // extended opcodes
`ifdef CTRL_EXT_ISA_EN
    op_d = OP_BNE; #1;
    chk("bne_branch_d", 32'(branch_d), 32'h1);
    tick(); chk("bne_ex", 32'(ex_bus()), 32'(8'b110_0_0_0_0_0));
    op_d = OP_ORI;
    tick(); chk("ori_ex", 32'(ex_bus()), 32'(8'b001_1_0_1_0_0));
`else
    op_d = OP_BNE; #1;
    chk("bne_branch_d", 32'(branch_d), 32'h0);
    tick(); chk("bne_ex", 32'(ex_bus()), 32'h0);
    op_d = OP_ORI;
    tick(); chk("ori_ex", 32'(ex_bus()), 32'h0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
